// File: rtl/fb_porta_arbiter.sv
// Two-requester arbiter for framebuffer BRAM port A: grant, registered issue, tagged read return.
// Define FB_ARB_FIXED_PRIO_EN for strict priority to requester 0 (default: round-robin).
module fb_porta_arbiter #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 32,
   parameter int FB_BYTES   = 307200
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  m0_req,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic [3:0]            m0_we,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   input  logic [3:0]            m1_we,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [ADDR_WIDTH-1:0] bram_addra,
   output logic [DATA_WIDTH-1:0] bram_dina,
   output logic [3:0]            bram_wea,
   output logic                  bram_ena,
   input  logic [DATA_WIDTH-1:0] bram_douta
);

   localparam logic [ADDR_WIDTH-1:0] FB_LIMIT = ADDR_WIDTH'(FB_BYTES);

   logic                  any_gnt;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [3:0]            sel_we;
   logic                  sel_in_range;
   logic                  sel_read;

   // Index 0 = issue stage, index 1 = return stage
   logic [1:0]            pipe_valid_reg;
   logic [1:0]            pipe_tag_reg;
   logic [1:0]            pipe_range_reg;

   logic [DATA_WIDTH-1:0] ret_data;
   logic [1:0]            rvalid_vec;
   logic [DATA_WIDTH-1:0] rdata_vec [2];
   logic [DATA_WIDTH-1:0] rdata_hold_reg [2];

`ifdef FB_ARB_FIXED_PRIO_EN
   always_comb begin
      m0_gnt = m0_req;
      m1_gnt = m1_req & ~m0_req;
   end
`else
   // Pointer names the last winner; on contention the other requester wins
   logic rr_ptr_reg;

   always_comb begin
      m0_gnt = m0_req & (~m1_req | rr_ptr_reg);
      m1_gnt = m1_req & (~m0_req | ~rr_ptr_reg);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_ptr_reg <= 1'b1;
      end else if (m0_gnt) begin
         rr_ptr_reg <= 1'b0;
      end else if (m1_gnt) begin
         rr_ptr_reg <= 1'b1;
      end
   end
`endif

   always_comb begin
      any_gnt      = m0_gnt | m1_gnt;
      sel_addr     = m1_gnt ? m1_addr  : m0_addr;
      sel_wdata    = m1_gnt ? m1_wdata : m0_wdata;
      sel_we       = m1_gnt ? m1_we    : m0_we;
      sel_in_range = sel_addr < FB_LIMIT;
      sel_read     = (sel_we == 4'b0000);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bram_ena   <= 1'b0;
         bram_wea   <= 4'b0000;
         bram_addra <= '0;
         bram_dina  <= '0;
      end else begin
         bram_ena <= any_gnt & sel_in_range;
         bram_wea <= (any_gnt & sel_in_range) ? sel_we : 4'b0000;
         if (any_gnt) begin
            bram_addra <= sel_addr;
            bram_dina  <= sel_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pipe_valid_reg <= 2'b00;
         pipe_tag_reg   <= 2'b00;
         pipe_range_reg <= 2'b00;
      end else begin
         pipe_valid_reg <= {pipe_valid_reg[0], any_gnt & sel_read};
         pipe_tag_reg   <= {pipe_tag_reg[0], m1_gnt};
         pipe_range_reg <= {pipe_range_reg[0], sel_in_range};
      end
   end

   // BRAM output is only valid in the return cycle, so it is forwarded then and held afterwards
   assign ret_data = pipe_range_reg[1] ? bram_douta : '0;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ret
         assign rvalid_vec[gi] = pipe_valid_reg[1] & (pipe_tag_reg[1] == 1'(gi));
         assign rdata_vec[gi]  = rvalid_vec[gi] ? ret_data : rdata_hold_reg[gi];

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               rdata_hold_reg[gi] <= '0;
            end else if (rvalid_vec[gi]) begin
               rdata_hold_reg[gi] <= ret_data;
            end
         end
      end
   endgenerate

   assign m0_rvalid = rvalid_vec[0];
   assign m1_rvalid = rvalid_vec[1];
   assign m0_rdata  = rdata_vec[0];
   assign m1_rdata  = rdata_vec[1];

endmodule

// File: tb/tb_fb_porta_arbiter.sv
// Directed, table-driven bench for fb_porta_arbiter with a read-first BRAM model on port A.
module tb_fb_porta_arbiter;

   logic        clk;
   logic        resetn;
   logic        m0_req, m1_req;
   logic [18:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic [3:0]  m0_we, m1_we;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [18:0] bram_addra;
   logic [31:0] bram_dina;
   logic [3:0]  bram_wea;
   logic        bram_ena;
   logic [31:0] bram_douta;

   int n_checks = 0;
   int n_fail   = 0;

   fb_porta_arbiter dut (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
      .bram_ena(bram_ena), .bram_douta(bram_douta)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Port A model: byte-enable write, read-first, 1-cycle latency
   logic [31:0] mem [0:131071];
   always @(posedge clk) begin
      if (bram_ena) begin
         for (int b = 0; b < 4; b++) begin
            if (bram_wea[b]) mem[bram_addra[18:2]][8*b +: 8] <= bram_dina[8*b +: 8];
         end
         bram_douta <= mem[bram_addra[18:2]];
      end
   end

   typedef struct {
      logic        r0; logic [18:0] a0; logic [31:0] d0; logic [3:0] w0;
      logic        r1; logic [18:0] a1; logic [31:0] d1; logic [3:0] w1;
      logic        g0; logic g1; logic ena; logic [3:0] wea;
      logic        chk_a; logic [18:0] addra;
      logic        rv0; logic [31:0] rd0; logic rv1; logic [31:0] rd1;
   } vec_t;

   vec_t vecs [21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_we = '0;
      m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_we = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   initial begin
      logic exp_g0, exp_g1;
      int   hist [8];

      // r0 a0 d0 w0 | r1 a1 d1 w1 | g0 g1 ena wea chk_a addra | rv0 rd0 rv1 rd1
      vecs[0]  = '{1'b1,19'h00000,32'h00000001,4'hF, 1'b0,19'h0,32'h0,4'h0,       1'b1,1'b0, 1'b0,4'h0,1'b0,19'h0,      1'b0,32'h0,1'b0,32'h0};
      vecs[1]  = '{1'b0,19'h0,32'h0,4'h0,             1'b1,19'h00004,32'h2,4'hF,   1'b0,1'b1, 1'b1,4'hF,1'b1,19'h00000,  1'b0,32'h0,1'b0,32'h0};
      vecs[2]  = '{1'b1,19'h00008,32'h00000003,4'hF, 1'b0,19'h0,32'h0,4'h0,       1'b1,1'b0, 1'b1,4'hF,1'b1,19'h00004,  1'b0,32'h0,1'b0,32'h0};
      vecs[3]  = '{1'b1,19'h00010,32'hDEADBEEF,4'hF, 1'b0,19'h0,32'h0,4'h0,       1'b1,1'b0, 1'b1,4'hF,1'b1,19'h00008,  1'b0,32'h0,1'b0,32'h0};
      vecs[4]  = '{1'b0,19'h0,32'h0,4'h0,             1'b1,19'h00010,32'h0,4'h0,   1'b0,1'b1, 1'b1,4'hF,1'b1,19'h00010,  1'b0,32'h0,1'b0,32'h0};
      vecs[5]  = '{1'b0,19'h0,32'h0,4'h0,             1'b0,19'h0,32'h0,4'h0,       1'b0,1'b0, 1'b1,4'h0,1'b1,19'h00010,  1'b0,32'h0,1'b0,32'h0};
      vecs[6]  = '{1'b0,19'h0,32'h0,4'h0,             1'b0,19'h0,32'h0,4'h0,       1'b0,1'b0, 1'b0,4'h0,1'b0,19'h0,      1'b0,32'h0,1'b1,32'hDEADBEEF};
      vecs[7]  = '{1'b0,19'h0,32'h0,4'h0,             1'b1,19'h4B000,32'h12345678,4'hF, 1'b0,1'b1, 1'b0,4'h0,1'b0,19'h0, 1'b0,32'h0,1'b0,32'hDEADBEEF};
      vecs[8]  = '{1'b0,19'h0,32'h0,4'h0,             1'b1,19'h4B000,32'h0,4'h0,   1'b0,1'b1, 1'b0,4'h0,1'b1,19'h4B000,  1'b0,32'h0,1'b0,32'hDEADBEEF};
      vecs[9]  = '{1'b0,19'h0,32'h0,4'h0,             1'b0,19'h0,32'h0,4'h0,       1'b0,1'b0, 1'b0,4'h0,1'b1,19'h4B000,  1'b0,32'h0,1'b0,32'hDEADBEEF};
      vecs[10] = '{1'b0,19'h0,32'h0,4'h0,             1'b0,19'h0,32'h0,4'h0,       1'b0,1'b0, 1'b0,4'h0,1'b0,19'h0,      1'b0,32'h0,1'b1,32'h0};
      vecs[11] = '{1'b1,19'h00000,32'h0,4'h0,         1'b0,19'h0,32'h0,4'h0,       1'b1,1'b0, 1'b0,4'h0,1'b0,19'h0,      1'b0,32'h0,1'b0,32'h0};
      vecs[12] = '{1'b0,19'h0,32'h0,4'h0,             1'b1,19'h00004,32'h0,4'h0,   1'b0,1'b1, 1'b1,4'h0,1'b1,19'h00000,  1'b0,32'h0,1'b0,32'h0};
      vecs[13] = '{1'b1,19'h00008,32'h0,4'h0,         1'b0,19'h0,32'h0,4'h0,       1'b1,1'b0, 1'b1,4'h0,1'b1,19'h00004,  1'b1,32'h1,1'b0,32'h0};
      vecs[14] = '{1'b0,19'h0,32'h0,4'h0,             1'b0,19'h0,32'h0,4'h0,       1'b0,1'b0, 1'b1,4'h0,1'b1,19'h00008,  1'b0,32'h1,1'b1,32'h2};
      vecs[15] = '{1'b0,19'h0,32'h0,4'h0,             1'b0,19'h0,32'h0,4'h0,       1'b0,1'b0, 1'b0,4'h0,1'b0,19'h0,      1'b1,32'h3,1'b0,32'h2};
      vecs[16] = '{1'b0,19'h0,32'h0,4'h0,             1'b0,19'h0,32'h0,4'h0,       1'b0,1'b0, 1'b0,4'h0,1'b0,19'h0,      1'b0,32'h3,1'b0,32'h2};
      vecs[17] = '{1'b1,19'h00000,32'hAAAABBBB,4'h3, 1'b0,19'h0,32'h0,4'h0,       1'b1,1'b0, 1'b0,4'h0,1'b0,19'h0,      1'b0,32'h3,1'b0,32'h2};
      vecs[18] = '{1'b1,19'h00000,32'h0,4'h0,         1'b0,19'h0,32'h0,4'h0,       1'b1,1'b0, 1'b1,4'h3,1'b1,19'h00000,  1'b0,32'h3,1'b0,32'h2};
      vecs[19] = '{1'b0,19'h0,32'h0,4'h0,             1'b0,19'h0,32'h0,4'h0,       1'b0,1'b0, 1'b1,4'h0,1'b1,19'h00000,  1'b0,32'h3,1'b0,32'h2};
      vecs[20] = '{1'b0,19'h0,32'h0,4'h0,             1'b0,19'h0,32'h0,4'h0,       1'b0,1'b0, 1'b0,4'h0,1'b0,19'h0,      1'b1,32'h0000BBBB,1'b0,32'h2};

      bram_douta = '0;
      do_reset();

      // Continuous dual requests straight out of reset
      for (int i = 0; i < 8; i++) begin
         if (i < 6) begin
            m0_req = 1'b1; m0_addr = 19'h00000; m0_we = 4'h0;
            m1_req = 1'b1; m1_addr = 19'h00004; m1_we = 4'h0;
         end else begin
            idle_inputs();
         end
`ifdef FB_ARB_FIXED_PRIO_EN
         exp_g0 = (i < 6);
`else
         exp_g0 = (i < 6) && (i % 2 == 0);
`endif
         exp_g1 = (i < 6) && !exp_g0;
         hist[i] = exp_g0 ? 0 : 1;
         @(negedge clk);
         check($sformatf("dual_gnt0[%0d]", i), 32'(m0_gnt), 32'(exp_g0));
         check($sformatf("dual_gnt1[%0d]", i), 32'(m1_gnt), 32'(exp_g1));
         if (i >= 2) begin
            check($sformatf("dual_rv0[%0d]", i), 32'(m0_rvalid), 32'(hist[i-2] == 0));
            check($sformatf("dual_rv1[%0d]", i), 32'(m1_rvalid), 32'(hist[i-2] == 1));
         end
         $display("dual cycle %0d: gnt0=%0b gnt1=%0b rv0=%0b rv1=%0b", i, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
         @(posedge clk); #1;
      end

      do_reset();
      @(negedge clk);
      check("reset_ena", 32'(bram_ena), 32'h0);
      check("reset_rv0", 32'(m0_rvalid), 32'h0);
      @(posedge clk); #1;

      foreach (vecs[k]) begin
         m0_req = vecs[k].r0; m0_addr = vecs[k].a0; m0_wdata = vecs[k].d0; m0_we = vecs[k].w0;
         m1_req = vecs[k].r1; m1_addr = vecs[k].a1; m1_wdata = vecs[k].d1; m1_we = vecs[k].w1;
         @(negedge clk);
         check($sformatf("v%0d_gnt0", k), 32'(m0_gnt), 32'(vecs[k].g0));
         check($sformatf("v%0d_gnt1", k), 32'(m1_gnt), 32'(vecs[k].g1));
         check($sformatf("v%0d_ena", k), 32'(bram_ena), 32'(vecs[k].ena));
         check($sformatf("v%0d_wea", k), 32'(bram_wea), 32'(vecs[k].wea));
         if (vecs[k].chk_a) check($sformatf("v%0d_addra", k), 32'(bram_addra), 32'(vecs[k].addra));
         check($sformatf("v%0d_rv0", k), 32'(m0_rvalid), 32'(vecs[k].rv0));
         check($sformatf("v%0d_rd0", k), m0_rdata, vecs[k].rd0);
         check($sformatf("v%0d_rv1", k), 32'(m1_rvalid), 32'(vecs[k].rv1));
         check($sformatf("v%0d_rd1", k), m1_rdata, vecs[k].rd1);
         $display("vec %0d: gnt=%0b%0b ena=%0b wea=%h addra=%h rv0=%0b rd0=%h rv1=%0b rd1=%h",
                  k, m0_gnt, m1_gnt, bram_ena, bram_wea, bram_addra, m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
         @(posedge clk); #1;
      end

      // Read in flight when reset hits must never return
      idle_inputs();
      m0_req = 1'b1; m0_addr = 19'h00008; m0_we = 4'h0;
      @(negedge clk);
      check("midrst_gnt0", 32'(m0_gnt), 32'h1);
      @(posedge clk); #1;
      idle_inputs();
      resetn = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("midrst_ena", 32'(bram_ena), 32'h0);
         check("midrst_wea", 32'(bram_wea), 32'h0);
         check("midrst_addra", 32'(bram_addra), 32'h0);
         check("midrst_dina", bram_dina, 32'h0);
         check("midrst_rv0", 32'(m0_rvalid), 32'h0);
         check("midrst_rv1", 32'(m1_rvalid), 32'h0);
         check("midrst_rd0", m0_rdata, 32'h0);
         check("midrst_rd1", m1_rdata, 32'h0);
         $display("reset held %0d: ena=%0b dina=%h rd0=%h rd1=%h", c, bram_ena, bram_dina, m0_rdata, m1_rdata);
         @(posedge clk); #1;
      end
      resetn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("postrst_rv0", 32'(m0_rvalid), 32'h0);
         check("postrst_rv1", 32'(m1_rvalid), 32'h0);
         $display("post-reset %0d: rv0=%0b rv1=%0b", c, m0_rvalid, m1_rvalid);
         @(posedge clk); #1;
      end

      // Reissued read recovers normally
      m0_req = 1'b1; m0_addr = 19'h00008; m0_we = 4'h0;
      @(negedge clk);
      check("reissue_gnt0", 32'(m0_gnt), 32'h1);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("reissue_ena", 32'(bram_ena), 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      check("reissue_rv0", 32'(m0_rvalid), 32'h1);
      check("reissue_rd0", m0_rdata, 32'h3);
      $display("reissue: rv0=%0b rd0=%h", m0_rvalid, m0_rdata);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
